// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: skid buffer depth and its occupancy type.
package pcie_phy_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] skid_cnt_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data: a read accepted in cycle N shows on rd_data_o in N+1.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_wr;
    logic                  w_rd;

    assign full_o    = (r_cnt == (AW+1)'(DEPTH));
    assign empty_o   = (r_cnt == '0);
    assign rd_data_o = r_rd_data;
    assign w_wr      = wr_en_i & ~full_o;
    assign w_rd      = rd_en_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read front end: 2-cycle FIFO-nonempty to m_valid_o, 1 word/cycle when m_ready_i stays high.
// A 2-entry skid buffer holds data while stalled; reads stop once buffered + in-flight words reach 2.
module fifo_stream_reader
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    input  logic                  flush_i,
    output logic                  busy_o
);

    if (SKID_DEPTH != pcie_phy_pkg::SKID_DEPTH) begin : g_bad_skid_depth
        $error("fifo_stream_reader: SKID_DEPTH must be 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    skid_cnt_t             r_cnt;
    logic                  r_inflight;

    logic                  w_pop;
    logic [2:0]            w_occupancy;
    logic [2:0]            w_limit;
    logic                  w_rd_en;

    assign m_valid_o   = (r_cnt != '0);
    assign m_data_o    = r_mem[r_rd_ptr];
    assign busy_o      = m_valid_o | r_inflight;

    // A pop this cycle frees a slot, so the read may be issued against it.
    assign w_pop       = m_valid_o & m_ready_i;
    assign w_occupancy = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign w_limit     = 3'd2 + {2'b00, w_pop};
    assign w_rd_en     = ~rst_i & ~flush_i & ~fifo_empty_i & (w_occupancy < w_limit);
    assign fifo_rd_en_o = w_rd_en;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (r_inflight) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt      <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
            r_inflight <= w_rd_en;
        end
    end

    // Entries are cleared on reset only so m_data_o is never X.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (r_inflight && !flush_i) begin
            r_mem[r_wr_ptr] <= fifo_data_i;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader fed by sync_fifo: queue-based reference model plus directed timing checks.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       flush;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int rd_seen    = 0;
    bit model_on   = 1'b0;

    // Reference model: upstream FIFO contents, skid contents, in-flight word.
    logic [7:0] fifo_q[$];
    logic [7:0] skid_q[$];
    bit         m_infl = 1'b0;
    logic [7:0] m_infl_w = '0;

    int         pop_cyc[$];
    logic [7:0] pop_dat[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_fifo #(.DEPTH(8), .DATA_WIDTH(8)) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .full_o    (fifo_full),
        .rd_en_i   (fifo_rd_en),
        .rd_data_o (fifo_data),
        .empty_o   (fifo_empty)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .SKID_DEPTH(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_data_i  (fifo_data),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .flush_i      (flush),
        .busy_o       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit pop;
        bit rd;
        bit wr_ok;
        int occ;
        pop   = (skid_q.size() != 0) && m_ready && !rst && !flush;
        occ   = skid_q.size() + int'(m_infl);
        rd    = !rst && !flush && (fifo_q.size() != 0) && (occ < 2 + int'(pop));
        wr_ok = wr_en && !rst && (fifo_q.size() < 8);

        if (model_on) begin
            chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, rd});
            chk("m_valid", {31'd0, m_valid}, {31'd0, skid_q.size() != 0});
            chk("busy", {31'd0, busy}, {31'd0, (skid_q.size() != 0) || m_infl});
            chk("m_data_known", {31'd0, $isunknown(m_data)}, 32'd0);
            if (skid_q.size() != 0) chk("m_data", {24'd0, m_data}, {24'd0, skid_q[0]});
        end

        if (m_valid && m_ready && !rst && !flush) begin
            pop_cyc.push_back(cyc);
            pop_dat.push_back(m_data);
        end
        if (fifo_rd_en) rd_seen++;

        if (rst) begin
            fifo_q.delete();
            skid_q.delete();
            m_infl = 1'b0;
        end else begin
            if (flush) begin
                skid_q.delete();
                m_infl = 1'b0;
            end else begin
                if (pop) void'(skid_q.pop_front());
                if (m_infl) skid_q.push_back(m_infl_w);
                m_infl = rd;
                if (rd) m_infl_w = fifo_q.pop_front();
            end
            if (wr_ok) fifo_q.push_back(wr_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        pop_cyc.delete();
        pop_dat.delete();
    endtask

    initial begin
        int t0;
        int words;
        int budget;
        bit idle_ok;
        logic [7:0] exp3 [3];
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; m_ready = 1'b0; flush = 1'b0;
        step();
        model_on = 1'b1;
        step();
        chk("reset_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_data", {24'd0, m_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rst = 1'b0;

        // Basic latency and back-to-back streaming.
        m_ready = 1'b1;
        step();
        clear_log();
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp3[i];
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 20 && pop_dat.size() < 3; i++) step();
        step();
        chk("t1_count", pop_dat.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (pop_dat.size() > i) begin
                chk("t1_data", {24'd0, pop_dat[i]}, {24'd0, exp3[i]});
                chk("t1_cycle", pop_cyc[i] - t0, 3 + i);
            end
        end
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // Stall with a full FIFO, then release.
        m_ready = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t2_stall_reads", rd_seen, 2);
        chk("t2_hold_valid", {31'd0, m_valid}, 32'd1);
        chk("t2_hold_data", {24'd0, m_data}, 32'h00);
        clear_log();
        m_ready = 1'b1;
        for (int i = 0; i < 40 && pop_dat.size() < 8; i++) step();
        chk("t2_count", pop_dat.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (pop_dat.size() > i) begin
                chk("t2_data", {24'd0, pop_dat[i]}, i);
                chk("t2_b2b", pop_cyc[i] - pop_cyc[0], i);
            end
        end

        // Flush the cycle after a read is issued from a full skid buffer.
        for (int i = 0; i < 5; i++) step();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        m_ready = 1'b1;
        step();
        flush = 1'b1;
        clear_log();
        step();
        flush = 1'b0;
        chk("t3_valid_after_flush", {31'd0, m_valid}, 32'd0);
        chk("t3_busy_after_flush", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20 && pop_dat.size() < 1; i++) step();
        for (int i = 0; i < 5; i++) step();
        chk("t3_count", pop_dat.size(), 1);
        if (pop_dat.size() > 0) chk("t3_first", {24'd0, pop_dat[0]}, 32'hA3);

        // Reset mid-stream while streaming steadily.
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'hB0 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("t4_pre_valid", {31'd0, m_valid}, 32'd1);
        chk("t4_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_valid", {31'd0, m_valid}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("t4_data", {24'd0, m_data}, 32'd0);
        clear_log();
        for (int i = 0; i < 10; i++) step();
        chk("t4_no_stale", pop_dat.size(), 0);
        wr_en = 1'b1; wr_data = 8'hC0;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 10 && pop_dat.size() < 1; i++) step();
        chk("t4_resume_count", pop_dat.size(), 1);
        if (pop_dat.size() > 0) chk("t4_resume_data", {24'd0, pop_dat[0]}, 32'hC0);

        // Idle with an empty FIFO.
        for (int i = 0; i < 5; i++) step();
        idle_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fifo_rd_en || m_valid || busy) idle_ok = 1'b0;
        end
        chk("t5_idle", {31'd0, idle_ok}, 32'd1);

        // Random traffic, random backpressure, rare flushes.
        words  = 0;
        budget = 0;
        while (words < 2000 && budget < 20000) begin
            m_ready = $urandom_range(1, 0) == 1;
            flush   = ($urandom_range(255, 0) == 0);
            if (($urandom_range(1, 0) == 1) && fifo_q.size() < 8) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                words++;
            end else begin
                wr_en = 1'b0;
            end
            step();
            budget++;
        end
        chk("t6_words_written", words, 2000);
        wr_en = 1'b0; flush = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 60 && (fifo_q.size() != 0 || skid_q.size() != 0 || m_infl); i++) step();
        step();
        chk("t6_drain_busy", {31'd0, busy}, 32'd0);
        chk("t6_drain_valid", {31'd0, m_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
